fetch_unit: RTL and testbench

Instruction-fetch stage of the RISC-V core, directly upstream of the control unit. Holds the program counter and fetches one instruction at a time from instruction memory over a req/ack handshake. Presents the fetched word to decode, whose `op`/`funct3`/`funct7` fields drive the control unit. Consumes the control unit's `pcSrc` together with the extended immediate to select the next PC.

---
 rtl/rv_pkg.sv | 16 +
 rtl/fetch_unit_pc_next.sv | 20 ++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared core types, reset PC default and opcode constants
package rv_pkg;
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_TRAP  = 2'd3
  } fetch_state_t;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: next-PC selection between pc+4 and branch target, with target alignment check
module pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_src,
  input  logic [XLEN-1:0] i_imm_ext,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misalign
);
  logic [XLEN-1:0] w_target;
  // Both sums wrap modulo 2^XLEN; the target is relative to the current pc
  always_comb begin
    o_pc_plus4 = i_pc + XLEN'(4);
    w_target   = i_pc + i_imm_ext;
    o_next_pc  = i_pc_src ? w_target : o_pc_plus4;
    o_misalign = i_pc_src && (w_target[1:0] != 2'b00);
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and single-outstanding instruction fetch over req/ack
module fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemAck,
  input  logic [31:0]     imemRdata,
  output logic            instrValid,
  input  logic            instrReady,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] immExt,
  output logic            misaligned,
  output logic [31:0]     retired
);
  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [31:0]     r_retired;
  logic            r_misaligned;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misalign;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .i_pc       (r_pc),
    .i_pc_src   (pcSrc),
    .i_imm_ext  (immExt),
    .o_pc_plus4 (pcPlus4),
    .o_next_pc  (w_next_pc),
    .o_misalign (w_misalign)
  );

  // Moore outputs decoded from state and registers only
  always_comb begin
    imemReq    = r_state == ST_FETCH;
    instrValid = r_state == ST_HOLD;
    imemAddr   = r_pc;
    pc         = r_pc;
    instr      = r_instr;
    retired    = r_retired;
    misaligned = r_misaligned;
  end

  // Fetch FSM: fetch until ack, hold until consumed, trap on a misaligned taken target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RESET;
      r_pc         <= RESET_PC;
      r_instr      <= 32'h0;
      r_retired    <= 32'h0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: r_state <= ST_FETCH;
        ST_FETCH: if (imemAck) begin
          r_instr <= imemRdata;
          r_state <= ST_HOLD;
        end
        ST_HOLD: if (instrReady) begin
          r_retired <= r_retired + 32'd1;
          if (w_misalign) begin
            r_misaligned <= 1'b1;
            r_state      <= ST_TRAP;
          end else begin
            r_pc    <= w_next_pc;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_TRAP;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: transaction-level reference model checks of the fetch stage
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        pcSrc = 1'b0;
  logic [31:0] immExt = 32'h0;
  logic        misaligned;
  logic [31:0] retired;

  int n_checks = 0;
  int n_pass = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] exp_instr;
  logic        exp_trap;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemAck    (imemAck),
    .imemRdata  (imemRdata),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .instr      (instr),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .pcSrc      (pcSrc),
    .immExt     (immExt),
    .misaligned (misaligned),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, imemReq, 0);
    check({tag, "_valid"}, instrValid, 0);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_misaligned"}, misaligned, 0);
    check({tag, "_instr"}, instr, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    imemAck = 1'b0;
    #1 check("release_req_low", imemReq, 0);
    exp_pc = 32'h0;
    exp_ret = 0;
    exp_instr = 0;
    exp_trap = 1'b0;
  endtask

  // One instruction: d wait cycles before ack, h cycles of instrReady=0 before consume
  task automatic run_instr(input int d, input int h, input logic src, input logic [31:0] imm, input logic spur);
    logic [31:0] word;
    logic [31:0] tgt;
    word = $urandom;
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      check("fetch_req", imemReq, 1);
      check("fetch_addr", imemAddr, exp_pc);
      check("fetch_valid", instrValid, 0);
      check("fetch_retired", retired, exp_ret);
      imemAck = (k == d);
      imemRdata = (k == d) ? word : $urandom;
      instrReady = 1'($urandom);
      pcSrc = 1'($urandom);
      immExt = $urandom;
    end
    exp_instr = word;
    for (int k = 0; k <= h; k++) begin
      @(negedge clk);
      check("hold_valid", instrValid, 1);
      check("hold_req", imemReq, 0);
      check("hold_instr", instr, exp_instr);
      check("hold_pc", pc, exp_pc);
      check("hold_pcplus4", pcPlus4, exp_pc + 32'd4);
      check("hold_retired", retired, exp_ret);
      imemAck = spur ? 1'($urandom) : 1'b0;
      imemRdata = $urandom;
      instrReady = (k == h);
      pcSrc = (k == h) ? src : 1'($urandom);
      immExt = (k == h) ? imm : $urandom;
    end
    exp_ret = exp_ret + 1;
    tgt = exp_pc + imm;
    if (src && tgt[1:0] != 2'b00) exp_trap = 1'b1;
    else exp_pc = src ? tgt : exp_pc + 32'd4;
  endtask

  task automatic check_trap(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("trap_req", imemReq, 0);
      check("trap_valid", instrValid, 0);
      check("trap_misaligned", misaligned, 1);
      check("trap_pc", pc, exp_pc);
      check("trap_retired", retired, exp_ret);
      imemAck = 1'($urandom);
      instrReady = 1'($urandom);
      pcSrc = 1'($urandom);
      immExt = $urandom;
    end
  endtask

  initial begin
    exp_trap = 1'b0;
    do_reset();
    // Sequential fetch 0x0, 0x4, 0x8 at full rate
    for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("retired_after_3", retired, 3);
    check("addr_after_3", imemAddr, 32'h0000_000C);
    imemAck = 1'b0;
    run_instr(0, 0, 1'b0, 32'h0, 1'b0);
    // Slow memory at 0x10
    run_instr(3, 0, 1'b0, 32'h0, 1'b0);
    // Jump from 0x14 to 0x20, then stall in HOLD and branch back by 8
    run_instr(1, 0, 1'b1, 32'h0000_000C, 1'b0);
    check("pc_at_0x20", exp_pc, 32'h0000_0020);
    run_instr(0, 5, 1'b1, 32'hFFFF_FFF8, 1'b1);
    // Branch to the top of the address space, then wrap via pc+4
    run_instr(0, 1, 1'b1, 32'hFFFF_FFFC - 32'h18, 1'b1);
    run_instr(0, 2, 1'b0, 32'h0, 1'b1);
    run_instr(0, 0, 1'b0, 32'h0, 1'b0);
    // Random aligned traffic
    for (int i = 0; i < 25; i++)
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                32'($signed(int'($urandom_range(0, 63)) - 32) * 4), 1'b1);
    // Reset asserted mid-fetch with an ack pending
    @(negedge clk);
    check("midfetch_req", imemReq, 1);
    imemAck = 1'b1;
    imemRdata = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1 check("async_req_drop", imemReq, 0);
    @(posedge clk);
    #1 check_reset_outputs("midfetch_reset");
    do_reset();
    // Jump to 0x40, then take a misaligned branch
    run_instr(0, 0, 1'b1, 32'h0000_0040, 1'b0);
    run_instr(2, 1, 1'b1, 32'h0000_0006, 1'b1);
    check("trap_expected", exp_trap, 1);
    check_trap(6);
    do_reset();
    run_instr(0, 0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check("post_trap_addr", imemAddr, 32'h4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
